mem_access_unit: RTL and testbench

- Memory-side responder for the MemRead/MemWrite/funct3 requests the pipeline issues on its data memory port.
- Converts each request into a multi-cycle access on a word-organised data memory with byte enables.
- Performs load extraction and sign/zero extension, and store byte-lane placement.
- Holds `stall` high until the access retires, then pulses `done` with the load result.

---
 rtl/mem_access_unit.sv | 200 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Data-memory responder: turns MemRead/MemWrite requests into word accesses with byte lanes,
// holding stall until the access retires. Optional counters under `MEM_ACCESS_STATS_EN`.
module mem_access_unit #(
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              done,
    output logic              misalign,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
`ifdef MEM_ACCESS_STATS_EN
    ,
    output logic [31:0]       load_cnt,
    output logic [31:0]       store_cnt,
    output logic [31:0]       misalign_cnt
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        f3_q, f3_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              store_q, store_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              misalign_q, misalign_d;
    logic              req, req_misal;

    // Access size: 0 = byte, 1 = halfword, 2 = word (reserved encodings fall back to word).
    function automatic logic [1:0] size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd2;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'd0:    return 1'b0;
            2'd1:    return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = w[{off[1], 4'b0000} +: 16];
        case (size_of(f3))
            2'd0:    return f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
            2'd1:    return f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        case (size_of(f3))
            2'd0:    return 4'b0001 << off;
            2'd1:    return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] w);
        case (size_of(f3))
            2'd0:    return {4{w[7:0]}};
            2'd1:    return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        f3_d       = f3_q;
        wdata_d    = wdata_q;
        store_d    = store_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        misalign_d = 1'b0;
        req        = MemRead | MemWrite;
        req_misal  = is_misaligned(size_of(funct3), addr[1:0]);

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (req_misal) begin
                        misalign_d = 1'b1;
                        rdata_d    = 32'd0;
                    end else begin
                        state_d = ST_ISSUE;
                        addr_d  = addr;
                        f3_d    = funct3;
                        wdata_d = wdata;
                        store_d = MemWrite;
                    end
                end
            end
            ST_ISSUE: begin
                if (store_q) begin
                    state_d = ST_DONE;
                    rdata_d = 32'd0;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = 4'(MEM_LATENCY);
                end
            end
            ST_WAIT: begin
                // The read word is valid in the last wait cycle, when the counter shows 1.
                if (cnt_q == 4'd1) begin
                    state_d = ST_DONE;
                    cnt_d   = 4'd0;
                    rdata_d = load_extend(f3_q, addr_q[1:0], mem_rdata);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            f3_q       <= 3'd0;
            wdata_q    <= 32'd0;
            store_q    <= 1'b0;
            cnt_q      <= 4'd0;
            rdata_q    <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            f3_q       <= f3_d;
            wdata_q    <= wdata_d;
            store_q    <= store_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
        end
    end

    assign stall     = ((state_q == ST_IDLE) && req && !req_misal)
                     || (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign done      = (state_q == ST_DONE);
    assign rdata     = rdata_q;
    assign misalign  = misalign_q;
    assign mem_en    = (state_q == ST_ISSUE);
    assign mem_addr  = addr_q[ADDR_W-1:2];
    assign mem_we    = ((state_q == ST_ISSUE) && store_q) ? store_be(f3_q, addr_q[1:0]) : 4'b0000;
    assign mem_wdata = ((state_q == ST_ISSUE) && store_q) ? store_data(f3_q, wdata_q) : 32'd0;

`ifdef MEM_ACCESS_STATS_EN
    logic [31:0] load_cnt_q, store_cnt_q, misalign_cnt_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt_q     <= 32'd0;
            store_cnt_q    <= 32'd0;
            misalign_cnt_q <= 32'd0;
        end else begin
            if (done && !store_q) load_cnt_q <= sat_inc(load_cnt_q);
            if (done && store_q)  store_cnt_q <= sat_inc(store_cnt_q);
            if (misalign_q)       misalign_cnt_q <= sat_inc(misalign_cnt_q);
        end
    end

    assign load_cnt     = load_cnt_q;
    assign store_cnt    = store_cnt_q;
    assign misalign_cnt = misalign_cnt_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: two instances (latency 1 and 3) share stimulus and are
// compared cycle by cycle against a transaction-level reference model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst, MemRead, MemWrite;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, mem_rdata;

    logic [31:0] rdata_a, rdata_b, mem_wdata_a, mem_wdata_b;
    logic        stall_a, stall_b, done_a, done_b, misalign_a, misalign_b, mem_en_a, mem_en_b;
    logic [3:0]  mem_we_a, mem_we_b;
    logic [29:0] mem_addr_a, mem_addr_b;
`ifdef MEM_ACCESS_STATS_EN
    logic [31:0] ld_cnt_a, st_cnt_a, mis_cnt_a, ld_cnt_b, st_cnt_b, mis_cnt_b;
`endif

    int n_chk = 0;
    int n_err = 0;
    int ref_ld = 0, ref_st = 0, ref_mis = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_LATENCY(1), .ADDR_W(32)) u_lat1 (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
        .addr(addr), .wdata(wdata), .rdata(rdata_a), .stall(stall_a), .done(done_a),
        .misalign(misalign_a), .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata)
`ifdef MEM_ACCESS_STATS_EN
        , .load_cnt(ld_cnt_a), .store_cnt(st_cnt_a), .misalign_cnt(mis_cnt_a)
`endif
    );

    mem_access_unit #(.MEM_LATENCY(3), .ADDR_W(32)) u_lat3 (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
        .addr(addr), .wdata(wdata), .rdata(rdata_b), .stall(stall_b), .done(done_b),
        .misalign(misalign_b), .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata)
`ifdef MEM_ACCESS_STATS_EN
        , .load_cnt(ld_cnt_b), .store_cnt(st_cnt_b), .misalign_cnt(mis_cnt_b)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference load result computed arithmetically from the byte offset.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] word);
        logic [31:0] sh, v;
        sh = word >> (8 * (a % 4));
        case (f3)
            3'd0: begin v = sh & 32'hFF;   if (v >= 32'd128)   v = v | 32'hFFFF_FF00; end
            3'd4: v = sh & 32'hFF;
            3'd1: begin v = sh & 32'hFFFF; if (v >= 32'd32768) v = v | 32'hFFFF_0000; end
            3'd5: v = sh & 32'hFFFF;
            default: v = word;
        endcase
        return v;
    endfunction

    task automatic check_idle_state(input string tag);
        check_val({tag, " done1"},  {31'd0, done_a},     32'd0);
        check_val({tag, " done3"},  {31'd0, done_b},     32'd0);
        check_val({tag, " men1"},   {31'd0, mem_en_a},   32'd0);
        check_val({tag, " men3"},   {31'd0, mem_en_b},   32'd0);
        check_val({tag, " stall1"}, {31'd0, stall_a},    32'd0);
        check_val({tag, " stall3"}, {31'd0, stall_b},    32'd0);
        check_val({tag, " mis1"},   {31'd0, misalign_a}, 32'd0);
        check_val({tag, " mis3"},   {31'd0, misalign_b}, 32'd0);
        check_val({tag, " rdata1"}, rdata_a,             32'd0);
        check_val({tag, " rdata3"}, rdata_b,             32'd0);
        check_val({tag, " mwe1"},   {28'd0, mem_we_a},   32'd0);
        check_val({tag, " mwd1"},   mem_wdata_a,         32'd0);
        check_val({tag, " maddr1"}, {2'd0, mem_addr_a},  32'd0);
    endtask

    task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word);
        int          nbytes, lat, dn;
        logic        ok;
        logic [31:0] exp_we, exp_wd, exp_rd;
        logic        st, dn_o, en_o, mis_o;
        logic [31:0] rd_o, wd_o;
        logic [3:0]  we_o;
        logic [29:0] ad_o;
        nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        ok     = (a % nbytes) == 0;
        exp_we = wr ? ((32'd1 << nbytes) - 32'd1) << (a % 4) : 32'd0;
        exp_wd = (nbytes == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
                 (nbytes == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
        exp_rd = wr ? 32'd0 : ref_load(f3, a, word);

        @(posedge clk); #1;
        MemRead = rd; MemWrite = wr; funct3 = f3; addr = a; wdata = wd; mem_rdata = word;
        for (int n = 0; n < 7; n++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                lat = (d == 0) ? 1 : 3;
                dn  = !ok ? -1 : (wr ? 2 : 2 + lat);
                if (d == 0) begin
                    st = stall_a; dn_o = done_a; en_o = mem_en_a; mis_o = misalign_a;
                    rd_o = rdata_a; wd_o = mem_wdata_a; we_o = mem_we_a; ad_o = mem_addr_a;
                end else begin
                    st = stall_b; dn_o = done_b; en_o = mem_en_b; mis_o = misalign_b;
                    rd_o = rdata_b; wd_o = mem_wdata_b; we_o = mem_we_b; ad_o = mem_addr_b;
                end
                check_val($sformatf("stall L%0d c%0d", lat, n), {31'd0, st},
                          {31'd0, (ok && n < dn)});
                check_val($sformatf("done L%0d c%0d", lat, n), {31'd0, dn_o}, {31'd0, (n == dn)});
                check_val($sformatf("mem_en L%0d c%0d", lat, n), {31'd0, en_o},
                          {31'd0, (ok && n == 1)});
                check_val($sformatf("misalign L%0d c%0d", lat, n), {31'd0, mis_o},
                          {31'd0, (!ok && n == 1)});
                if (ok && n == 1) begin
                    check_val($sformatf("mem_addr L%0d", lat), {2'd0, ad_o}, a >> 2);
                    check_val($sformatf("mem_we L%0d", lat), {28'd0, we_o}, exp_we);
                    if (wr) check_val($sformatf("mem_wdata L%0d", lat), wd_o, exp_wd);
                end
                if (n == dn) check_val($sformatf("rdata L%0d a=%h f3=%0d", lat, a, f3), rd_o, exp_rd);
                if (!ok && n == 1) check_val($sformatf("rdata_mis L%0d", lat), rd_o, 32'd0);
            end
            @(posedge clk); #1;
            MemRead = 1'b0; MemWrite = 1'b0;
            addr = $urandom; wdata = $urandom; funct3 = 3'($urandom);
        end
        if (!ok) ref_mis++;
        else if (wr) ref_st++;
        else ref_ld++;
`ifdef MEM_ACCESS_STATS_EN
        check_val("load_cnt1", ld_cnt_a, ref_ld);
        check_val("store_cnt1", st_cnt_a, ref_st);
        check_val("misalign_cnt1", mis_cnt_a, ref_mis);
        check_val("load_cnt3", ld_cnt_b, ref_ld);
        check_val("store_cnt3", st_cnt_b, ref_st);
        check_val("misalign_cnt3", mis_cnt_b, ref_mis);
`endif
    endtask

    initial begin
        logic [1:0]  kind;
        logic [2:0]  f3;
        rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'd0;
        addr = 32'd0; wdata = 32'd0; mem_rdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_state("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        run_txn(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 32'h0);
        run_txn(1'b0, 1'b1, 3'd0, 32'h13, 32'h0000_00A5, 32'h0);
        run_txn(1'b1, 1'b0, 3'd0, 32'h21, 32'h0, 32'h0000_8000);
        run_txn(1'b1, 1'b0, 3'd4, 32'h21, 32'h0, 32'h0000_8000);
        run_txn(1'b1, 1'b0, 3'd1, 32'h22, 32'h0, 32'h8001_1234);
        run_txn(1'b1, 1'b0, 3'd2, 32'h06, 32'h0, 32'h1234_5678);
        run_txn(1'b1, 1'b1, 3'd1, 32'h02, 32'h0000_BEEF, 32'h0);
        run_txn(1'b1, 1'b0, 3'd6, 32'h08, 32'h0, 32'hCAFE_F00D);
        run_txn(1'b0, 1'b1, 3'd1, 32'h05, 32'h1111_2222, 32'h0);

        // Reset arriving while a load is waiting on memory.
        @(posedge clk); #1;
        MemRead = 1'b1; funct3 = 3'd1; addr = 32'h22; mem_rdata = 32'h8001_1234;
        @(negedge clk);
        @(posedge clk); #1;
        MemRead = 1'b0;
        @(negedge clk);
        check_val("rst_pre men1", {31'd0, mem_en_a}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_idle_state("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_state("rst_after");
        ref_ld = 0; ref_st = 0; ref_mis = 0;
        run_txn(1'b0, 1'b1, 3'd2, 32'h40, 32'h0BAD_F00D, 32'h0);

        for (int i = 0; i < 40; i++) begin
            kind = 2'($urandom_range(1, 3));
            f3   = kind[1] ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            run_txn(kind[0], kind[1], f3, $urandom, $urandom, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
